// File: rtl/vga_sync_if.sv
// Pixel-timing bundle between the VGA sync generator and whatever consumes
// its raster position. The generator side is the master: it receives the
// pixel enable and drives sync, blanking and position back out.
interface vga_sync_if;
  logic       tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_end;
  logic       frame_end;

  modport master (
    input  tick,
    output hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_end
  );

  modport slave (
    output tick,
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_end
  );
endinterface

// File: rtl/vga_sync.sv
// VGA raster timing generator. Walks a pixel/line counter pair at the rate
// of the incoming pixel enable and produces active-low syncs, the visible
// area flag and end-of-line / end-of-frame strobes. Sync and blanking are
// registered from the next-state counters so they line up with the
// position presented in the same cycle.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input logic clk,
  input logic reset,
  vga_sync_if.master bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_STOP  = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_STOP  = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] x_q, y_q;
  logic [9:0] x_d, y_d;
  logic       hsync_q, vsync_q, video_on_q;
  logic       hsync_d, vsync_d, video_on_d;
  logic       at_line_last;
  logic       at_frame_last;

  assign at_line_last  = (x_q == H_LAST);
  assign at_frame_last = (y_q == V_LAST);

  // Next raster position: advance one pixel per tick, wrapping line and frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (bus.tick) begin
      if (at_line_last) begin
        x_d = 10'd0;
        y_d = at_frame_last ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Decode sync and visible area from the upcoming position, not the current one.
  always_comb begin
    hsync_d    = !((x_d >= H_SYNC_START) && (x_d < H_SYNC_STOP));
    vsync_d    = !((y_d >= V_SYNC_START) && (y_d < V_SYNC_STOP));
    video_on_d = (x_d < H_VISIBLE) && (y_d < V_VISIBLE);
  end

  // State only moves on a pixel enable; reset parks the raster at the origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else if (bus.tick) begin
      x_q        <= x_d;
      y_q        <= y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign bus.pixel_x   = x_q;
  assign bus.pixel_y   = y_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.video_on  = video_on_q;
  assign bus.line_end  = !reset && bus.tick && at_line_last;
  assign bus.frame_end = bus.line_end && at_frame_last;

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync. Uses a shrunken raster so several whole
// frames fit in a short run; the expected raster is derived from a single
// tick count since reset, independent of how the design counts.
module tb_vga_sync;

  localparam int HD = 40, HF = 4, HS = 8, HB = 4;
  localparam int VD = 30, VF = 3, VS = 2, VB = 5;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  localparam int STALL_T = 10 * HT + (HD + HF - 1);
  localparam int MID_T   = 15 * HT + 20;

  logic clk = 1'b0;
  logic reset;

  vga_sync_if bus ();

  vga_sync #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int t          = 0;
  int hsLow      = 0;
  int lineTicks  = 0;
  int sinceFrame = 0;

  function automatic int modelX();
    return t % HT;
  endfunction

  function automatic int modelY();
    return t / HT;
  endfunction

  function automatic bit modelHsync();
    int x = modelX();
    return !(x >= HD + HF && x < HD + HF + HS);
  endfunction

  function automatic bit modelVsync();
    int y = modelY();
    return !(y >= VD + VF && y < VD + VF + VS);
  endfunction

  function automatic bit modelVideoOn();
    return (modelX() < HD) && (modelY() < VD);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic checkState();
    checkOutput("pixel_x",  32'(bus.pixel_x),  32'(modelX()));
    checkOutput("pixel_y",  32'(bus.pixel_y),  32'(modelY()));
    checkOutput("hsync",    32'(bus.hsync),    32'(modelHsync()));
    checkOutput("vsync",    32'(bus.vsync),    32'(modelVsync()));
    checkOutput("video_on", 32'(bus.video_on), 32'(modelVideoOn()));
  endtask

  task automatic checkResetState();
    checkOutput("rst_pixel_x",   32'(bus.pixel_x),   32'd0);
    checkOutput("rst_pixel_y",   32'(bus.pixel_y),   32'd0);
    checkOutput("rst_hsync",     32'(bus.hsync),     32'd1);
    checkOutput("rst_vsync",     32'(bus.vsync),     32'd1);
    checkOutput("rst_video_on",  32'(bus.video_on),  32'd1);
    checkOutput("rst_line_end",  32'(bus.line_end),  32'd0);
    checkOutput("rst_frame_end", 32'(bus.frame_end), 32'd0);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic applyStimulus(input bit tk);
    bit lastPix, lastLine;
    checkState();
    bus.tick = tk;
    #1;
    lastPix  = (modelX() == HT - 1);
    lastLine = (modelY() == VT - 1);
    checkOutput("line_end",  32'(bus.line_end),  32'(tk && lastPix));
    checkOutput("frame_end", 32'(bus.frame_end), 32'(tk && lastPix && lastLine));
    if (tk) begin
      if (!bus.hsync) hsLow++;
      lineTicks++;
      sinceFrame++;
      if (lastPix) begin
        checkOutput("hsync_low_ticks", 32'(hsLow), 32'(HS));
        checkOutput("line_period", 32'(lineTicks), 32'(HT));
        hsLow     = 0;
        lineTicks = 0;
        if (lastLine) begin
          checkOutput("frame_period", 32'(sinceFrame), 32'(FT));
          sinceFrame = 0;
        end
      end
      t = (t + 1) % FT;
    end
    @(negedge clk);
  endtask

  task automatic runUntil(input int target, input bit allHigh, input int budget);
    int n = 0;
    while (t != target && n < budget) begin
      applyStimulus(allHigh ? 1'b1 : ($urandom_range(0, 3) != 0));
      n++;
    end
    checkOutput("reach_x", 32'(bus.pixel_x), 32'(target % HT));
    checkOutput("reach_y", 32'(bus.pixel_y), 32'(target / HT));
  endtask

  task automatic clearModel();
    t          = 0;
    hsLow      = 0;
    lineTicks  = 0;
    sinceFrame = 0;
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    bus.tick = 1'b0;
    repeat (2) @(negedge clk);

    // Reset held with the pixel enable toggling
    for (int i = 0; i < 8; i++) begin
      bus.tick = i[0];
      #1;
      checkResetState();
      @(negedge clk);
    end
    reset    = 1'b0;
    bus.tick = 1'b0;
    clearModel();

    // Pixel enable every fourth clock for two lines
    for (int c = 0; c < 8 * HT; c++) applyStimulus((c % 4) == 3);

    // Random pacing up to the pixel just before horizontal sync
    runUntil(STALL_T, 1'b0, 4 * FT);
    repeat (50) applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("stall_next_x",     32'(bus.pixel_x), 32'(HD + HF));
    checkOutput("stall_next_y",     32'(bus.pixel_y), 32'd10);
    checkOutput("stall_next_hsync", 32'(bus.hsync),   32'd0);

    // Continuous enable to the last pixel of the frame, then wrap
    runUntil(FT - 1, 1'b1, FT + 10);
    applyStimulus(1'b1);
    checkOutput("wrap_x",        32'(bus.pixel_x),  32'd0);
    checkOutput("wrap_y",        32'(bus.pixel_y),  32'd0);
    checkOutput("wrap_video_on", 32'(bus.video_on), 32'd1);
    checkOutput("wrap_vsync",    32'(bus.vsync),    32'd1);

    // A whole frame of random pacing
    runUntil(FT - 1, 1'b0, 4 * FT);
    applyStimulus(1'b1);

    // Reset pulse in the middle of a frame
    runUntil(MID_T, 1'b0, 4 * FT);
    bus.tick = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkResetState();
    @(negedge clk);
    checkResetState();
    reset    = 1'b0;
    bus.tick = 1'b0;
    clearModel();
    applyStimulus(1'b1);
    checkOutput("post_reset_x", 32'(bus.pixel_x), 32'd1);
    checkOutput("post_reset_y", 32'(bus.pixel_y), 32'd0);
    runUntil(FT - 1, 1'b1, FT + 10);
    applyStimulus(1'b1);
    checkOutput("post_reset_wrap_x", 32'(bus.pixel_x), 32'd0);
    checkOutput("post_reset_wrap_y", 32'(bus.pixel_y), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
